// File: rtl/cz80_alu_reg_if.sv
// -----------------------------------------------------------------------------
// cz80_alu_reg_if
//   Operand/result bundle between the cz80 sequencer and its registered ALU.
//
//   Timing contract: there is no valid/ready pair. The ALU is always ready and
//   every rising clock edge is a transaction: whatever the master presents on
//   the operand/control signals at edge N is reflected on q/f_out right after
//   edge N and held until edge N+1.
//
//   Signals
//     arith16  16-bit ADD/ADC/SBC step (S,Z,P come from f_in for ops 0-7)
//     z16      16-bit ADC/SBC high byte (zero result keeps f_in Z)
//     alu_cpi  CPI/CPD/CPIR/CPDR compare (CP keeps f_in C)
//     alu_op   operation select
//     ir       ir[5:3] bit index / rotate type, ir[2:0] operand field
//     iset     instruction set, 2'b00 = unprefixed
//     busa     operand A
//     busb     operand B
//     f_in     current flags {S,Z,Y,H,X,P/V,N,C}
//     q        registered result
//     f_out    registered flags
//
//   Modports: master drives operands and samples results; slave is the ALU.
// -----------------------------------------------------------------------------
interface cz80_alu_reg_if;
  logic       arith16;
  logic       z16;
  logic       alu_cpi;
  logic [3:0] alu_op;
  logic [5:0] ir;
  logic [1:0] iset;
  logic [7:0] busa;
  logic [7:0] busb;
  logic [7:0] f_in;
  logic [7:0] q;
  logic [7:0] f_out;

  modport master (
    output arith16, z16, alu_cpi, alu_op, ir, iset, busa, busb, f_in,
    input  q, f_out
  );

  modport slave (
    input  arith16, z16, alu_cpi, alu_op, ir, iset, busa, busb, f_in,
    output q, f_out
  );
endinterface

// File: rtl/cz80_alu_reg.sv
// -----------------------------------------------------------------------------
// cz80_alu_reg
//   Z80 8-bit ALU for the cz80 core. Computes the result byte and the complete
//   flag byte from the operands and the incoming F, matching T80_ALU bit for
//   bit, then registers both (one clock of latency) ahead of the register file
//   and the F latch.
//
//   Operations (alu_op)
//     0 ADD  1 ADC  2 SUB  3 SBC  4 AND  5 XOR  6 OR  7 CP
//     8 rotate/shift by ir[5:3]   9 BIT   10 SET   11 RES
//     12 DAA  13 RLD  14 RRD  15 pass busa, keep F
//
//   Ports
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset, clears q and f_out
//     bus      cz80_alu_reg_if.slave (operands in, q/f_out out)
//
//   Configuration
//     CZ80_ALU_UNDOC_XY_EN  defined: undocumented X/Y flags (f_out[3], f_out[5])
//                           are computed by each operation.
//                           undefined: X/Y are copied from f_in for every op.
//
//   No FSM: the block is a combinational core followed by one register stage.
// -----------------------------------------------------------------------------
module cz80_alu_reg (
  input  logic          clk,
  input  logic          reset_n,
  cz80_alu_reg_if.slave bus
);

  // Flag bit positions inside F.
  localparam int FLAG_C = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_X = 3;
  localparam int FLAG_H = 4;
  localparam int FLAG_Y = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;

  // Local aliases of the interface inputs.
  logic       arith16;
  logic       z16;
  logic       alu_cpi;
  logic [3:0] alu_op;
  logic [5:0] ir;
  logic [1:0] iset;
  logic [7:0] busa;
  logic [7:0] busb;
  logic [7:0] f_in;

  assign arith16 = bus.arith16;
  assign z16     = bus.z16;
  assign alu_cpi = bus.alu_cpi;
  assign alu_op  = bus.alu_op;
  assign ir      = bus.ir;
  assign iset    = bus.iset;
  assign busa    = bus.busa;
  assign busb    = bus.busb;
  assign f_in    = bus.f_in;

  // ---------------------------------------------------------------------------
  // Adder / subtractor.
  // Split into 4 + 3 + 1 bit slices so the half carry (out of bit 3) and the
  // carry into bit 7 (needed for overflow) are available directly.
  // Subtraction is A + ~B + 1; SBC folds the borrow in as an inverted carry.
  // ---------------------------------------------------------------------------
  logic       add_sub;
  logic       add_cin;
  logic [7:0] b_eff;
  logic [4:0] sum_lo;
  logic [3:0] sum_mid;
  logic [1:0] sum_hi;
  logic       half_c;
  logic       carry7;
  logic       carry_o;
  logic       ovf;
  logic [7:0] sum;

  assign add_sub = alu_op[1];
  assign add_cin = add_sub ^ (alu_op[0] & ~alu_op[2] & f_in[FLAG_C]);
  assign b_eff   = add_sub ? ~busb : busb;

  assign sum_lo  = {1'b0, busa[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, add_cin};
  assign half_c  = sum_lo[4];
  assign sum_mid = {1'b0, busa[6:4]} + {1'b0, b_eff[6:4]} + {3'b000, half_c};
  assign carry7  = sum_mid[3];
  assign sum_hi  = {1'b0, busa[7]} + {1'b0, b_eff[7]} + {1'b0, carry7};
  assign carry_o = sum_hi[1];
  assign ovf     = carry7 ^ carry_o;
  assign sum     = {sum_hi[0], sum_mid[2:0], sum_lo[3:0]};

  // ---------------------------------------------------------------------------
  // Bit mask for BIT/SET/RES.
  // ---------------------------------------------------------------------------
  logic [2:0] bit_idx;
  logic [7:0] bit_mask;

  assign bit_idx  = ir[5:3];
  assign bit_mask = 8'b0000_0001 << bit_idx;

  // ---------------------------------------------------------------------------
  // Rotate / shift unit, always operating on busa.
  // ---------------------------------------------------------------------------
  logic [7:0] rot_q;
  logic       rot_c;

  always_comb begin
    rot_q = busa;
    rot_c = busa[7];
    case (ir[5:3])
      3'd0: begin // RLC
        rot_q = {busa[6:0], busa[7]};
        rot_c = busa[7];
      end
      3'd1: begin // RRC
        rot_q = {busa[0], busa[7:1]};
        rot_c = busa[0];
      end
      3'd2: begin // RL through carry
        rot_q = {busa[6:0], f_in[FLAG_C]};
        rot_c = busa[7];
      end
      3'd3: begin // RR through carry
        rot_q = {f_in[FLAG_C], busa[7:1]};
        rot_c = busa[0];
      end
      3'd4: begin // SLA
        rot_q = {busa[6:0], 1'b0};
        rot_c = busa[7];
      end
      3'd5: begin // SRA keeps the sign bit
        rot_q = {busa[7], busa[7:1]};
        rot_c = busa[0];
      end
      3'd6: begin // SLL (undocumented) shifts a one in
        rot_q = {busa[6:0], 1'b1};
        rot_c = busa[7];
      end
      default: begin // SRL
        rot_q = {1'b0, busa[7:1]};
        rot_c = busa[0];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // DAA. Works on a 9-bit value so the decimal carry out of the high digit is
  // visible in bit 8. After subtraction (N=1) the low-digit fix-up only touches
  // the low byte, while the high-digit fix-up is a full 9-bit subtract of 0x160.
  // ---------------------------------------------------------------------------
  logic [8:0] daa_d;
  logic       daa_h;

  always_comb begin
    daa_d = {1'b0, busa};
    daa_h = f_in[FLAG_H];
    if (!f_in[FLAG_N]) begin
      if ((daa_d[3:0] > 4'd9) || f_in[FLAG_H]) begin
        daa_h = (daa_d[3:0] > 4'd9);
        daa_d = daa_d + 9'd6;
      end
      if ((daa_d[8:4] > 5'd9) || f_in[FLAG_C]) begin
        daa_d = daa_d + 9'h060;
      end
    end else begin
      if ((busa[3:0] > 4'd9) || f_in[FLAG_H]) begin
        if (busa[3:0] > 4'd5) begin
          daa_h = 1'b0;
        end
        daa_d[7:0] = daa_d[7:0] - 8'd6;
      end
      if ((busa > 8'h99) || f_in[FLAG_C]) begin
        daa_d = daa_d - 9'h160;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result and flag selection. F defaults to f_in; each op overrides only the
  // flags it defines.
  // ---------------------------------------------------------------------------
  logic [7:0] q_nxt;
  logic [7:0] f_core;

  always_comb begin
    q_nxt  = busa;
    f_core = f_in;

    if (!alu_op[3]) begin
      // Ops 0-7: arithmetic, logic and compare.
      f_core[FLAG_N] = 1'b0;
      f_core[FLAG_C] = 1'b0;
      case (alu_op[2:0])
        3'd0, 3'd1: begin
          q_nxt          = sum;
          f_core[FLAG_C] = carry_o;
          f_core[FLAG_H] = half_c;
          f_core[FLAG_P] = ovf;
        end
        3'd2, 3'd3, 3'd7: begin
          // Z80 carry/half-carry mean borrow after a subtract.
          q_nxt          = sum;
          f_core[FLAG_N] = 1'b1;
          f_core[FLAG_C] = ~carry_o;
          f_core[FLAG_H] = ~half_c;
          f_core[FLAG_P] = ovf;
        end
        3'd4: begin
          q_nxt          = busa & busb;
          f_core[FLAG_H] = 1'b1;
          f_core[FLAG_P] = ~^(busa & busb);
        end
        3'd5: begin
          q_nxt          = busa ^ busb;
          f_core[FLAG_H] = 1'b0;
          f_core[FLAG_P] = ~^(busa ^ busb);
        end
        default: begin
          q_nxt          = busa | busb;
          f_core[FLAG_H] = 1'b0;
          f_core[FLAG_P] = ~^(busa | busb);
        end
      endcase

      // Block compares must not disturb the carry the loop relies on.
      if ((alu_op[2:0] == 3'd7) && alu_cpi) begin
        f_core[FLAG_C] = f_in[FLAG_C];
      end

      // CP takes X/Y from the operand, not from the discarded difference.
      if (alu_op[2:0] == 3'd7) begin
        f_core[FLAG_X] = busb[3];
        f_core[FLAG_Y] = busb[5];
      end else begin
        f_core[FLAG_X] = q_nxt[3];
        f_core[FLAG_Y] = q_nxt[5];
      end

      f_core[FLAG_S] = q_nxt[7];
      if (q_nxt == 8'h00) begin
        // High byte of a 16-bit ADC/SBC: Z accumulates across both bytes.
        f_core[FLAG_Z] = z16 ? f_in[FLAG_Z] : 1'b1;
      end else begin
        f_core[FLAG_Z] = 1'b0;
      end

      if (arith16) begin
        f_core[FLAG_S] = f_in[FLAG_S];
        f_core[FLAG_Z] = f_in[FLAG_Z];
        f_core[FLAG_P] = f_in[FLAG_P];
      end
    end else begin
      case (alu_op[2:0])
        3'd0: begin // rotate / shift
          q_nxt          = rot_q;
          f_core[FLAG_C] = rot_c;
          f_core[FLAG_H] = 1'b0;
          f_core[FLAG_N] = 1'b0;
          f_core[FLAG_X] = rot_q[3];
          f_core[FLAG_Y] = rot_q[5];
          // Unprefixed RLCA/RRCA/RLA/RRA leave S, Z and P alone.
          if (iset != 2'b00) begin
            f_core[FLAG_S] = rot_q[7];
            f_core[FLAG_Z] = (rot_q == 8'h00);
            f_core[FLAG_P] = ~^rot_q;
          end
        end
        3'd1: begin // BIT
          q_nxt          = busb & bit_mask;
          f_core[FLAG_S] = q_nxt[7];
          f_core[FLAG_Z] = (q_nxt == 8'h00);
          f_core[FLAG_P] = (q_nxt == 8'h00);
          f_core[FLAG_H] = 1'b1;
          f_core[FLAG_N] = 1'b0;
          // BIT n,(HL) leaks internal state on real silicon; T80 reports 0.
          if (ir[2:0] != 3'b110) begin
            f_core[FLAG_X] = busb[3];
            f_core[FLAG_Y] = busb[5];
          end else begin
            f_core[FLAG_X] = 1'b0;
            f_core[FLAG_Y] = 1'b0;
          end
        end
        3'd2: begin // SET
          q_nxt = busb | bit_mask;
        end
        3'd3: begin // RES
          q_nxt = busb & ~bit_mask;
        end
        3'd4: begin // DAA, N is preserved
          q_nxt          = daa_d[7:0];
          f_core[FLAG_H] = daa_h;
          f_core[FLAG_C] = f_in[FLAG_C] | daa_d[8];
          f_core[FLAG_S] = daa_d[7];
          f_core[FLAG_Z] = (daa_d[7:0] == 8'h00);
          f_core[FLAG_P] = ~^daa_d[7:0];
          f_core[FLAG_X] = daa_d[3];
          f_core[FLAG_Y] = daa_d[5];
        end
        3'd5, 3'd6: begin // RLD (13) / RRD (14): nibble exchange result for A
          q_nxt          = {busa[7:4], (alu_op[0] ? busb[7:4] : busb[3:0])};
          f_core[FLAG_H] = 1'b0;
          f_core[FLAG_N] = 1'b0;
          f_core[FLAG_S] = q_nxt[7];
          f_core[FLAG_Z] = (q_nxt == 8'h00);
          f_core[FLAG_P] = ~^q_nxt;
          f_core[FLAG_X] = q_nxt[3];
          f_core[FLAG_Y] = q_nxt[5];
        end
        default: begin // 15: pass-through
          q_nxt = busa;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Undocumented X/Y selection.
  // ---------------------------------------------------------------------------
  logic [7:0] f_nxt;

`ifdef CZ80_ALU_UNDOC_XY_EN
  assign f_nxt = f_core;
`else
  // Bits 3 and 5 pass through from f_in; everything else from the core.
  assign f_nxt = (f_core & 8'hD7) | (f_in & 8'h28);
`endif

  // ---------------------------------------------------------------------------
  // Output register.
  // ---------------------------------------------------------------------------
  logic [7:0] q_r;
  logic [7:0] f_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= 8'h00;
      f_r <= 8'h00;
    end else begin
      q_r <= q_nxt;
      f_r <= f_nxt;
    end
  end

  assign bus.q     = q_r;
  assign bus.f_out = f_r;

endmodule

// File: tb/tb_cz80_alu_reg.sv
// -----------------------------------------------------------------------------
// tb_cz80_alu_reg
//   Directed vectors with known answers, then randomized vectors compared with
//   a behavioural Z80 ALU model written from the flag rules using plain integer
//   arithmetic. Expected {q, f_out} pairs go through exp_q.
// -----------------------------------------------------------------------------
module tb_cz80_alu_reg;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cz80_alu_reg_if bus ();

  cz80_alu_reg dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // X/Y come from f_in unless the undocumented-flag build is selected.
  function automatic logic [7:0] xy_fix(input logic [7:0] f, input logic [7:0] fi);
`ifdef CZ80_ALU_UNDOC_XY_EN
    return f;
`else
    return {f[7:6], fi[5], f[4], fi[3], f[2:0]};
`endif
  endfunction

  // ---------------------------------------------------------------- reference
  function automatic logic [15:0] ref_alu(
    input logic [3:0] op, input logic [5:0] irv, input logic [1:0] isv,
    input logic a16, input logic z16v, input logic cpi,
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi);
    int         ia, ib, cy, r, sr, d;
    logic [7:0] res, f, mask;
    logic       sh_in;
    ia   = int'(a);
    ib   = int'(b);
    res  = a;
    f    = fi;
    mask = 8'h01 << irv[5:3];
    if (op <= 4'd7) begin
      f[1] = 1'b0;
      f[0] = 1'b0;
      if (op == 4'd0 || op == 4'd1) begin
        cy   = (op == 4'd1) ? int'(fi[0]) : 0;
        r    = ia + ib + cy;
        res  = r[7:0];
        f[0] = (r > 255);
        f[4] = ((ia % 16) + (ib % 16) + cy) > 15;
        sr   = int'($signed(a)) + int'($signed(b)) + cy;
        f[2] = (sr > 127) || (sr < -128);
      end else if (op == 4'd2 || op == 4'd3 || op == 4'd7) begin
        cy   = (op == 4'd3) ? int'(fi[0]) : 0;
        r    = ia - ib - cy;
        res  = r[7:0];
        f[0] = (r < 0);
        f[4] = ((ia % 16) - (ib % 16) - cy) < 0;
        sr   = int'($signed(a)) - int'($signed(b)) - cy;
        f[2] = (sr > 127) || (sr < -128);
        f[1] = 1'b1;
        if (op == 4'd7 && cpi) f[0] = fi[0];
      end else begin
        res  = (op == 4'd4) ? (a & b) : (op == 4'd5) ? (a ^ b) : (a | b);
        f[4] = (op == 4'd4);
        f[2] = ~^res;
      end
      f[3] = (op == 4'd7) ? b[3] : res[3];
      f[5] = (op == 4'd7) ? b[5] : res[5];
      f[7] = res[7];
      f[6] = (res == 8'h00) ? (z16v ? fi[6] : 1'b1) : 1'b0;
      if (a16) begin
        f[7] = fi[7];
        f[6] = fi[6];
        f[2] = fi[2];
      end
    end else if (op == 4'd8) begin
      if (irv[3] == 1'b0) begin
        case (irv[5:3])
          3'd0:    sh_in = a[7];
          3'd2:    sh_in = fi[0];
          3'd4:    sh_in = 1'b0;
          default: sh_in = 1'b1;
        endcase
        f[0] = a[7];
        res  = {a[6:0], sh_in};
      end else begin
        case (irv[5:3])
          3'd1:    sh_in = a[0];
          3'd3:    sh_in = fi[0];
          3'd5:    sh_in = a[7];
          default: sh_in = 1'b0;
        endcase
        f[0] = a[0];
        res  = {sh_in, a[7:1]};
      end
      f[4] = 1'b0;
      f[1] = 1'b0;
      f[3] = res[3];
      f[5] = res[5];
      if (isv != 2'b00) begin
        f[7] = res[7];
        f[6] = (res == 8'h00);
        f[2] = ~^res;
      end
    end else if (op == 4'd9) begin
      res  = b & mask;
      f[7] = res[7];
      f[6] = (res == 8'h00);
      f[2] = (res == 8'h00);
      f[4] = 1'b1;
      f[1] = 1'b0;
      f[3] = (irv[2:0] != 3'b110) ? b[3] : 1'b0;
      f[5] = (irv[2:0] != 3'b110) ? b[5] : 1'b0;
    end else if (op == 4'd10) begin
      res = b | mask;
    end else if (op == 4'd11) begin
      res = b & ~mask;
    end else if (op == 4'd12) begin
      d = ia;
      if (!fi[1]) begin
        if ((d % 16) > 9 || fi[4]) begin
          f[4] = (d % 16) > 9;
          d    = d + 6;
        end
        if ((d / 16) > 9 || fi[0]) d = d + 96;
      end else begin
        if ((d % 16) > 9 || fi[4]) begin
          if ((d % 16) > 5) f[4] = 1'b0;
          d = (d - 6) & 255;
        end
        if (ia > 153 || fi[0]) d = (d - 352) & 511;
      end
      d    = d & 511;
      res  = d[7:0];
      f[0] = fi[0] | d[8];
      f[7] = res[7];
      f[6] = (res == 8'h00);
      f[2] = ~^res;
      f[3] = res[3];
      f[5] = res[5];
    end else if (op == 4'd13 || op == 4'd14) begin
      res  = {a[7:4], (op == 4'd13) ? b[7:4] : b[3:0]};
      f[4] = 1'b0;
      f[1] = 1'b0;
      f[7] = res[7];
      f[6] = (res == 8'h00);
      f[2] = ~^res;
      f[3] = res[3];
      f[5] = res[5];
    end else begin
      res = a;
    end
    return {res, xy_fix(f, fi)};
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic set_in(
    input logic [3:0] op, input logic [5:0] irv, input logic [1:0] isv,
    input logic a16, input logic z16v, input logic cpi,
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi);
    bus.alu_op  = op;
    bus.ir      = irv;
    bus.iset    = isv;
    bus.arith16 = a16;
    bus.z16     = z16v;
    bus.alu_cpi = cpi;
    bus.busa    = a;
    bus.busb    = b;
    bus.f_in    = fi;
  endtask

  // Wait for the capturing edge, then compare one step after it.
  task automatic step(input string tag);
    logic [15:0] e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check8({tag, ".q"}, bus.q, e[15:8]);
    check8({tag, ".f"}, bus.f_out, e[7:0]);
  endtask

  task automatic directed(input string tag,
    input logic [3:0] op, input logic [5:0] irv, input logic [1:0] isv,
    input logic a16, input logic z16v, input logic cpi,
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi,
    input logic [7:0] eq, input logic [7:0] ef);
    set_in(op, irv, isv, a16, z16v, cpi, a, b, fi);
    exp_q.push_back({eq, xy_fix(ef, fi)});
    step(tag);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [3:0] r_op;
    logic [5:0] r_ir;
    logic [1:0] r_is;
    logic       r_a16, r_z16, r_cpi;
    logic [7:0] r_a, r_b, r_f;

    reset_n = 1'b1;
    set_in(4'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    #1 reset_n = 1'b0;
    #2;
    check8("reset.q", bus.q, 8'h00);
    check8("reset.f", bus.f_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    //        tag         op     ir          iset   a16   z16   cpi   busa   busb   f_in   q      f
    directed("add",      4'd0,  6'b000000,  2'd1,  1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h94);
    directed("sub",      4'd2,  6'b000000,  2'd1,  1'b0, 1'b0, 1'b0, 8'h10, 8'h01, 8'h00, 8'h0F, 8'h1A);
    directed("cp",       4'd7,  6'b000000,  2'd1,  1'b0, 1'b0, 1'b0, 8'h05, 8'h28, 8'h00, 8'hDD, 8'hBB);
    directed("cpi",      4'd7,  6'b000000,  2'd1,  1'b0, 1'b0, 1'b1, 8'h05, 8'h28, 8'h00, 8'hDD, 8'hBA);
    directed("daa",      4'd12, 6'b000000,  2'd0,  1'b0, 1'b0, 1'b0, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h55);
    directed("bit7",     4'd9,  6'b111000,  2'd1,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h55);
    directed("rl_cb",    4'd8,  6'b010000,  2'd1,  1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01);
    directed("add_z16",  4'd0,  6'b000000,  2'd1,  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    directed("add_a16",  4'd0,  6'b000000,  2'd1,  1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'hC4, 8'h00, 8'hD5);
    directed("rrca",     4'd8,  6'b001000,  2'd0,  1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'hC4, 8'h80, 8'hC5);
    directed("set3",     4'd10, 6'b011110,  2'd1,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h08, 8'h5A);
    directed("pass",     4'd15, 6'b000000,  2'd0,  1'b0, 1'b0, 1'b0, 8'h3C, 8'h77, 8'hA5, 8'h3C, 8'hA5);

    for (int i = 0; i < 3000; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_ir  = 6'($urandom_range(0, 63));
      r_is  = 2'($urandom_range(0, 3));
      r_a16 = ($urandom_range(0, 7) == 0);
      r_z16 = ($urandom_range(0, 3) == 0);
      r_cpi = 1'($urandom_range(0, 1));
      r_a   = 8'($urandom_range(0, 255));
      r_b   = 8'($urandom_range(0, 255));
      r_f   = 8'($urandom_range(0, 255));
      // Make zero results common enough to exercise Z/z16 paths.
      if ($urandom_range(0, 9) == 0) r_b = r_a;
      set_in(r_op, r_ir, r_is, r_a16, r_z16, r_cpi, r_a, r_b, r_f);
      exp_q.push_back(ref_alu(r_op, r_ir, r_is, r_a16, r_z16, r_cpi, r_a, r_b, r_f));
      step("rand");
    end

    // Asynchronous reset between clock edges must clear outputs at once.
    #2 reset_n = 1'b0;
    #1;
    check8("areset.q", bus.q, 8'h00);
    check8("areset.f", bus.f_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    directed("post_rst", 4'd4, 6'b000000, 2'd1, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h00, 8'h30, 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
